// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer: FSM state encoding and run modes.
package interval_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle of the interval timer; master drives requests, slave is the timer.
interface interval_timer_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    logic                  start_i;
    logic                  abort_i;
    logic                  pause_i;
    logic                  mode_i;
    logic [WIDTH-1:0]      count_i;
    logic [PRESCALE_W-1:0] prescale_i;
    logic                  busy_o;
    logic                  done_o;
    logic [WIDTH-1:0]      remaining_o;

    modport master (
        output start_i, abort_i, pause_i, mode_i, count_i, prescale_i,
        input  busy_o, done_o, remaining_o
    );

    modport slave (
        input  start_i, abort_i, pause_i, mode_i, count_i, prescale_i,
        output busy_o, done_o, remaining_o
    );
endinterface

// File: rtl/interval_timer_prescaler.sv
// Clock divider producing one tick every divider+1 enabled clocks.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] divider,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] phase_q;

    assign tick = enable && !clear && (phase_q == divider);

    // The phase only advances while enabled, so a frozen run resumes on the same phase.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= tick ? '0 : phase_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer with one-shot/periodic modes, pause and abort.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    interval_timer_if.slave  bus
);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      n_q;
    logic [PRESCALE_W-1:0] p_q;
    logic                  mode_q;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic                  launch, cancel, tick, run_ends;

    assign launch = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i;
    assign cancel = (state_q != ST_IDLE) && bus.abort_i;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (launch || cancel),
        .enable  (state_q == ST_RUN),
        .divider (p_q),
        .tick    (tick)
    );

    // Abort outranks everything; otherwise a tick in RUN is applied before pause picks RUN/HOLD.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
        run_ends = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = bus.pause_i ? ST_HOLD : ST_RUN;
                    count_d = bus.count_i;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    if (state_q == ST_RUN && tick) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                count_d = n_q;
                            end else begin
                                run_ends = 1'b1;
                            end
                        end
                    end
                    if (run_ends) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = bus.pause_i ? ST_HOLD : ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            n_q     <= '0;
            p_q     <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= (state_d != ST_IDLE);
            if (launch) begin
                n_q    <= bus.count_i;
                p_q    <= bus.prescale_i;
                mode_q <= bus.mode_i;
            end
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.remaining_o = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed and randomized checks of interval_timer against a tick-arithmetic reference model.
module tb_interval_timer;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    interval_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

    interval_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;

    logic m_busy, m_done, m_held, m_mode;
    int   m_n, m_p, m_k, m_rem;

    // Reference: count enabled clocks k since launch; tick t = k/(P+1); position in period = t mod (N+1).
    task automatic modelStep();
        int t, j;
        if (rst_i) begin
            m_busy = 1'b0; m_done = 1'b0; m_held = 1'b0; m_mode = 1'b0;
            m_n = 0; m_p = 0; m_k = 0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.start_i && !bus.abort_i) begin
                    m_busy = 1'b1;
                    m_n    = int'(bus.count_i);
                    m_p    = int'(bus.prescale_i);
                    m_mode = bus.mode_i;
                    m_k    = 0;
                    m_rem  = m_n;
                    m_held = bus.pause_i;
                end
            end else if (bus.abort_i) begin
                m_busy = 1'b0;
                m_rem  = 0;
            end else begin
                if (!m_held) begin
                    m_k++;
                    if (m_k % (m_p + 1) == 0) begin
                        t = m_k / (m_p + 1);
                        j = t % (m_n + 1);
                        if (j == 0) begin
                            m_done = 1'b1;
                            if (m_mode) m_rem = m_n;
                            else begin
                                m_busy = 1'b0;
                                m_rem  = 0;
                            end
                        end else begin
                            m_rem = m_n - j;
                        end
                    end
                end
                m_held = bus.pause_i;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] exp_rem;
        exp_rem = m_rem[WIDTH-1:0];
        vectors++;
        assert (bus.busy_o === m_busy) else begin
            miscompares++;
            $error("[TB] FAIL %s busy_o observed=%0b expected=%0b", tag, bus.busy_o, m_busy);
        end
        vectors++;
        assert (bus.done_o === m_done) else begin
            miscompares++;
            $error("[TB] FAIL %s done_o observed=%0b expected=%0b", tag, bus.done_o, m_done);
        end
        vectors++;
        assert (bus.remaining_o === exp_rem) else begin
            miscompares++;
            $error("[TB] FAIL %s remaining_o observed=%0d expected=%0d", tag, bus.remaining_o, exp_rem);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag);
        modelStep();
        @(posedge clk_i);
        #1;
        checkOutput(tag);
    endtask

    task automatic launchRun(input logic mode, input int n, input int p, input string tag);
        bus.start_i    = 1'b1;
        bus.mode_i     = mode;
        bus.count_i    = n[WIDTH-1:0];
        bus.prescale_i = p[PRESCALE_W-1:0];
        applyStimulus(tag);
        bus.start_i    = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int bound, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            applyStimulus(tag);
            cycles++;
            if (bus.done_o) seen = 1'b1;
        end
        vectors++;
        assert (seen) else begin
            miscompares++;
            $error("[TB] FAIL %s done_o observed=none expected=pulse within %0d cycles", tag, bound);
        end
    endtask

    initial begin
        int cycles, busy_cnt, done_cnt, first_done, last_done, base, guard;

        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.pause_i = 1'b0; bus.mode_i = 1'b0;
        bus.count_i = '0;   bus.prescale_i = '0;

        rst_i = 1'b1;
        applyStimulus("reset");
        applyStimulus("reset");
        rst_i = 1'b0;

        // One-shot N=3 P=0
        launchRun(1'b0, 3, 0, "oneshot_start");
        busy_cnt = bus.busy_o ? 1 : 0;
        cycles = 0;
        while (cycles < 20 && !bus.done_o) begin
            applyStimulus("oneshot_run");
            cycles++;
            if (bus.busy_o) busy_cnt++;
        end
        checkValue("oneshot_busy_cycles", busy_cnt, 4);
        checkValue("oneshot_done_latency", cycles, 4);
        applyStimulus("oneshot_after");

        // Periodic N=2 P=1: done every 6 clocks
        launchRun(1'b1, 2, 1, "periodic_start");
        busy_cnt = 0; done_cnt = 0; first_done = 0; last_done = 0;
        for (int i = 1; i <= 18; i++) begin
            applyStimulus("periodic_run");
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
                last_done = i;
            end
        end
        checkValue("periodic_busy_cycles", busy_cnt, 18);
        checkValue("periodic_done_count", done_cnt, 3);
        checkValue("periodic_first_done", first_done, 6);
        checkValue("periodic_last_done", last_done, 18);
        bus.abort_i = 1'b1;
        applyStimulus("periodic_abort");
        bus.abort_i = 1'b0;

        // Pause delays expiry by exactly the paused cycles
        launchRun(1'b0, 5, 0, "pause_ref_start");
        waitDone("pause_ref", 20, base);
        checkValue("pause_ref_latency", base, 6);
        launchRun(1'b0, 5, 0, "pause_start");
        applyStimulus("pause_pre");
        applyStimulus("pause_pre");
        bus.pause_i = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus("pause_hold");
        bus.pause_i = 1'b0;
        waitDone("pause_post", 20, cycles);
        checkValue("pause_delay", 6 + cycles - base, 4);

        // Abort at remaining 1
        launchRun(1'b0, 4, 0, "abort1_start");
        guard = 0;
        while (bus.remaining_o != 1 && guard < 20) begin
            applyStimulus("abort1_run");
            guard++;
        end
        bus.abort_i = 1'b1;
        applyStimulus("abort1");
        bus.abort_i = 1'b0;
        checkValue("abort1_done", int'(bus.done_o), 0);
        applyStimulus("abort1_after");

        // Abort coincident with the terminal tick
        launchRun(1'b0, 2, 0, "abortT_start");
        guard = 0;
        while (bus.remaining_o != 0 && guard < 20) begin
            applyStimulus("abortT_run");
            guard++;
        end
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        applyStimulus("abortT");
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        checkValue("abortT_done", int'(bus.done_o), 0);
        applyStimulus("abortT_after");

        // start while busy is ignored
        launchRun(1'b0, 4, 0, "restart_start");
        applyStimulus("restart_run");
        applyStimulus("restart_run");
        bus.start_i = 1'b1;
        bus.count_i = 8'd9;
        applyStimulus("restart_ignored");
        applyStimulus("restart_ignored");
        bus.start_i = 1'b0;
        waitDone("restart_tail", 20, cycles);
        checkValue("restart_total", 4 + cycles, 5);

        // Reset mid-run
        launchRun(1'b1, 10, 2, "rst_start");
        for (int i = 0; i < 5; i++) applyStimulus("rst_run");
        rst_i = 1'b1;
        applyStimulus("rst_mid");
        rst_i = 1'b0;
        checkValue("rst_mid_remaining", int'(bus.remaining_o), 0);

        // Boundary counts
        launchRun(1'b0, 0, 0, "n0_start");
        waitDone("n0", 10, cycles);
        checkValue("n0_latency", cycles, 1);
        launchRun(1'b0, (1 << WIDTH) - 1, 0, "nmax_start");
        waitDone("nmax", (1 << WIDTH) + 20, cycles);
        checkValue("nmax_latency", cycles, 1 << WIDTH);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_i          = ($urandom_range(0, 199) == 0);
            bus.start_i    = ($urandom_range(0, 5) == 0);
            bus.abort_i    = ($urandom_range(0, 39) == 0);
            bus.pause_i    = ($urandom_range(0, 5) == 0);
            bus.mode_i     = 1'($urandom_range(0, 1));
            bus.count_i    = WIDTH'($urandom_range(0, 6));
            bus.prescale_i = PRESCALE_W'($urandom_range(0, 3));
            applyStimulus("random");
        end
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
- REQ-001: Parameter WIDTH, default 16, width of the count and reload value.
- REQ-002: Parameter PRESCALE_W, default 8, width of the prescale divider value.
- REQ-003: clk_i  input  1  single clock; all logic rising-edge.
- REQ-004: rst_i  input  1  reset; synchronous, active-high.
- REQ-005: start_i  input  1  request a new timing run; sampled only in IDLE.
- REQ-006: abort_i  input  1  cancel the current run.
- REQ-007: pause_i  input  1  freeze the count and prescaler while high.
- REQ-008: mode_i  input  1  0 = one-shot, 1 = periodic auto-reload; latched at start.
- REQ-009: count_i  input  WIDTH  terminal count N; latched at start.
- REQ-010: prescale_i  input  PRESCALE_W  divider P, one tick per P+1 clocks; latched at start.
- REQ-011: busy_o  output  1  high while a run is active (RUN or HOLD).
- REQ-012: done_o  output  1  single-cycle pulse at each period expiry.
- REQ-013: remaining_o  output  WIDTH  current down-count value.

Function
- REQ-014: The FSM SHALL have three states: IDLE, RUN, HOLD.
- REQ-015: IDLE with start_i=1 and abort_i=0 SHALL latch N, P and mode, load the count with N, clear the prescaler, and enter RUN (or HOLD if pause_i=1) on the next edge; busy_o rises on that edge.
- REQ-016: start_i SHALL be ignored in RUN and HOLD; the run is not restarted.
- REQ-017: A tick SHALL occur in RUN when the prescaler equals the latched P; the prescaler then clears, otherwise it increments. P=0 gives a tick every clock.
- REQ-018: On a tick with count≠0, the count SHALL decrement by 1.
- REQ-019: On a tick with count=0 in one-shot mode, done_o SHALL pulse and busy_o SHALL fall on the same edge; state returns to IDLE and the count holds 0.
- REQ-020: On a tick with count=0 in periodic mode, done_o SHALL pulse, the count SHALL reload the latched N, and busy_o SHALL stay high.
- REQ-021: Each period SHALL span (N+1)·(P+1) clocks; N=0 expires on the first tick.
- REQ-022: pause_i=1 in RUN SHALL move the FSM to HOLD, freezing the count and prescaler. pause_i=0 in HOLD SHALL return it to RUN with no tick lost or gained.
- REQ-023: abort_i=1 in RUN or HOLD SHALL return the FSM to IDLE on the next edge, clear the count and prescaler, and drop busy_o, with no done_o pulse.
- REQ-024: abort_i SHALL take priority over start_i, terminal count and pause_i in the same cycle.
- REQ-025: Count arithmetic SHALL be unsigned WIDTH-bit; the count never wraps below 0.
- REQ-026: done_o SHALL never be high for two consecutive cycles when P≥1, and SHALL be registered.

Reset
- REQ-027: rst_i=1 SHALL force IDLE, count=0, prescaler=0, latched N/P/mode=0, busy_o=0, done_o=0 and remaining_o=0 on the next edge, including mid-run.
- REQ-028: rst_i SHALL take priority over every other input.

Structure
- REQ-029: Package interval_timer_pkg SHALL hold the state encoding (IDLE, RUN, HOLD) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
- REQ-030: The prescaler SHALL be a sub-module, tick_prescaler, with inputs clear, enable and divider, and output tick.
- REQ-031: All outputs SHALL be driven directly from registers.

Verification
- REQ-032: One-shot with N=3, P=0, start pulse -> busy_o high 4 cycles, done_o one pulse on the busy_o falling edge, remaining_o 3,2,1,0.
- REQ-033: Periodic with N=2, P=1 -> done_o every 6 clocks for 3 periods, busy_o continuously high, remaining_o reloads to 2.
- REQ-034: One-shot with N=5, P=0, pause_i high 4 cycles mid-run -> done_o delayed exactly 4 cycles versus the unpaused run.
- REQ-035: Abort at remaining_o=1, and abort coincident with the terminal tick -> no done_o, busy_o low next cycle, remaining_o=0.
- REQ-036: start_i asserted while busy with a new count_i=9 -> ignored, original N=4 completes; rst_i mid-run -> all outputs 0 next cycle.
- REQ-037: N=0 with P=0, and N=2^WIDTH-1 with P=0 -> done_o after 1 and 2^WIDTH ticks respectively.
